// File: rtl/weight_plane_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : weight_plane_fetcher_if
//  Brief    : Weight-word stream from the plane fetcher to the PE array.
//             master = producer (fetcher), slave = consumer (PE array).
//  Revision : 1.0  initial release
// ============================================================================
interface weight_plane_fetcher_if #(
    parameter int DATA_W = 32,
    parameter int PB_W   = 5
);
    logic [DATA_W-1:0] out_data;
    logic [PB_W-1:0]   out_plane;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_plane,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_plane,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/weight_plane_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : weight_plane_fetcher
//  Brief    : Multi-resolution weight fetcher. Walks bit-plane-ordered groups
//             in the weight SRAM, reading planes 0..budget of each group and
//             skipping the rest, and streams the words out through a small
//             credit-protected FIFO.
//             Optional macro WFETCH_STALL_CNT_EN adds a saturating
//             back-pressure cycle counter on stall_cycles_o.
//  Revision : 1.0  initial release
// ============================================================================
module weight_plane_fetcher #(
    parameter int LANES       = 4,
    parameter int LANE_W      = 8,
    parameter int PLANES      = 32,
    parameter int PB_W        = $clog2(PLANES),
    parameter int SRAM_ADDR_W = 18,
    parameter int SRAM_LAT    = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start_i,
    input  logic [SRAM_ADDR_W-1:0]    base_addr_i,
    input  logic [SRAM_ADDR_W-1:0]    end_addr_i,
    input  logic [PB_W-1:0]           wgt_budget_i,
    output logic                      sram_en_o,
    output logic [SRAM_ADDR_W-1:0]    sram_addr_o,
    input  logic [LANES*LANE_W-1:0]   sram_data_i,
    weight_plane_fetcher_if.master    out_if,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [31:0]               stall_cycles_o
);
    localparam int C_DATA_W = LANES * LANE_W;
    localparam int C_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int C_OCC_W  = C_PTR_W + 1;
    localparam logic [SRAM_ADDR_W:0] C_GRP_STEP = (SRAM_ADDR_W+1)'(PLANES);
    localparam logic [C_OCC_W-1:0]   C_DEPTH    = C_OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SRAM_ADDR_W-1:0] grp_q, end_q, sram_addr_q;
    logic [PB_W-1:0]        plane_q, budget_q, tag_plane_q;
    logic                   sram_en_q, tag_last_q, busy_q, done_q;

    // Tag pipeline aligned with the SRAM read latency
    logic                   pipe_vld_q   [SRAM_LAT];
    logic [PB_W-1:0]        pipe_plane_q [SRAM_LAT];
    logic                   pipe_last_q  [SRAM_LAT];

    // Output FIFO and credit accounting
    logic [C_DATA_W-1:0]    fifo_data_q  [FIFO_DEPTH];
    logic [PB_W-1:0]        fifo_plane_q [FIFO_DEPTH];
    logic                   fifo_last_q  [FIFO_DEPTH];
    logic [C_PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [C_OCC_W-1:0]     fifo_cnt_q, occ_q;

    logic                   w_start_acc, w_issue, w_credit, w_push, w_pop;
    logic                   w_pop_last, w_plane_end, w_last, w_out_valid;
    logic [SRAM_ADDR_W-1:0] w_cur_grp, w_cur_end;
    logic [PB_W-1:0]        w_cur_plane, w_cur_budget;
    logic [SRAM_ADDR_W:0]   w_next_grp;

    // The first read is issued straight from IDLE using the live inputs, so
    // the walk position is taken from the inputs there and from state later.
    assign w_start_acc  = (state_q == S_IDLE) && start_i && !done_q;
    assign w_cur_grp    = (state_q == S_IDLE) ? base_addr_i  : grp_q;
    assign w_cur_end    = (state_q == S_IDLE) ? end_addr_i   : end_q;
    assign w_cur_plane  = (state_q == S_IDLE) ? '0           : plane_q;
    assign w_cur_budget = (state_q == S_IDLE) ? wgt_budget_i : budget_q;

    // Group-end compare is one bit wider so a step past the top of the
    // address space counts as "beyond end" rather than wrapping to zero.
    assign w_next_grp   = {1'b0, w_cur_grp} + C_GRP_STEP;
    assign w_plane_end  = (w_cur_plane == w_cur_budget);
    assign w_last       = w_plane_end && (w_next_grp > {1'b0, w_cur_end});

    assign w_out_valid  = (fifo_cnt_q != '0);
    assign w_pop        = w_out_valid && out_if.out_ready;
    assign w_push       = pipe_vld_q[SRAM_LAT-1];
    assign w_pop_last   = w_pop && fifo_last_q[rd_ptr_q];

    // occ_q counts FIFO entries plus reads still in flight; a slot freed by
    // this cycle's pop may be reused immediately.
    assign w_credit     = (occ_q - {{(C_OCC_W-1){1'b0}}, w_pop}) < C_DEPTH;
    assign w_issue      = w_start_acc || ((state_q == S_FETCH) && w_credit);

    // Job control FSM: address walk, registered SRAM request and status
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            grp_q       <= '0;
            end_q       <= '0;
            plane_q     <= '0;
            budget_q    <= '0;
            sram_en_q   <= 1'b0;
            sram_addr_q <= '0;
            tag_plane_q <= '0;
            tag_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            sram_en_q <= w_issue;
            if (w_issue) begin
                sram_addr_q <= w_cur_grp + SRAM_ADDR_W'(w_cur_plane);
                tag_plane_q <= w_cur_plane;
                tag_last_q  <= w_last;
                if (w_plane_end) begin
                    plane_q <= '0;
                    grp_q   <= w_next_grp[SRAM_ADDR_W-1:0];
                end else begin
                    plane_q <= w_cur_plane + PB_W'(1);
                    grp_q   <= w_cur_grp;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (w_start_acc) begin
                        end_q    <= end_addr_i;
                        budget_q <= wgt_budget_i;
                        busy_q   <= 1'b1;
                        state_q  <= w_last ? S_DRAIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_issue && w_last) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop_last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read-tag delay line and outstanding-credit counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SRAM_LAT; i++) begin
                pipe_vld_q[i]   <= 1'b0;
                pipe_plane_q[i] <= '0;
                pipe_last_q[i]  <= 1'b0;
            end
            occ_q <= '0;
        end else begin
            pipe_vld_q[0]   <= sram_en_q;
            pipe_plane_q[0] <= tag_plane_q;
            pipe_last_q[0]  <= tag_last_q;
            for (int i = 1; i < SRAM_LAT; i++) begin
                pipe_vld_q[i]   <= pipe_vld_q[i-1];
                pipe_plane_q[i] <= pipe_plane_q[i-1];
                pipe_last_q[i]  <= pipe_last_q[i-1];
            end
            occ_q <= occ_q + {{(C_OCC_W-1){1'b0}}, w_issue}
                           - {{(C_OCC_W-1){1'b0}}, w_pop};
        end
    end

    // Output FIFO: captures returning words, head entry drives the stream
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i]  <= '0;
                fifo_plane_q[i] <= '0;
                fifo_last_q[i]  <= 1'b0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (w_push) begin
                fifo_data_q[wr_ptr_q]  <= sram_data_i;
                fifo_plane_q[wr_ptr_q] <= pipe_plane_q[SRAM_LAT-1];
                fifo_last_q[wr_ptr_q]  <= pipe_last_q[SRAM_LAT-1];
                wr_ptr_q               <= wr_ptr_q + C_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + C_OCC_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - C_OCC_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign out_if.out_valid = w_out_valid;
    assign out_if.out_data  = fifo_data_q[rd_ptr_q];
    assign out_if.out_plane = fifo_plane_q[rd_ptr_q];
    assign out_if.out_last  = fifo_last_q[rd_ptr_q];
    assign sram_en_o        = sram_en_q;
    assign sram_addr_o      = sram_addr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

`ifdef WFETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of job cycles where a valid word is held off
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (w_start_acc) begin
            stall_q <= '0;
        end else if (busy_q && w_out_valid && !out_if.out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule
`default_nettype wire
